pipe_stage_ctrl: RTL and testbench

- Generic control register for one MIPS pipeline stage boundary (E, M or W).
- Carries the write-back control bundle (valid, RegWr, write address, write-data select, PC+4) and a Tnew countdown.
- Supports stall (hold) and flush (bubble insertion).
- Provides combinational rs/rt hazard results (forward-ready, stall-request) against this stage's registered contents.
- One instance per stage replaces the per-stage hand-written control registers.

---
 rtl/pipe_stage_ctrl.sv | 96 +++++++++
 tb/tb_pipe_stage_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: control register for one MIPS pipeline stage boundary.
// Holds the write-back control bundle and the Tnew countdown for the
// instruction currently in this stage. It also compares that bundle against
// a consumer's rs/rt operands and reports whether to forward or stall.
//
// Advance protocol (one rule for the whole block): on each rising edge,
// flush=1 loads a bubble (all fields 0) whatever en is. Otherwise en=1
// captures the upstream bundle, and en=0 holds every field, tnew included.
// There is no ready/valid backpressure inside this block. The stall decision
// belongs to the surrounding hazard unit, which drives en.
module pipe_stage_ctrl #(
  parameter int ADDR_W         = 5,
  parameter int SEL_W          = 2,
  parameter int TNEW_W         = 2,
  parameter int PC_W           = 32,
  parameter int DEC_ON_CAPTURE = 1,
  parameter int ZERO_REG_HAZ   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regwr,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [SEL_W-1:0]  in_wdsel,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [PC_W-1:0]   in_pc4,
  output logic              valid,
  output logic              regwr,
  output logic [ADDR_W-1:0] waddr,
  output logic [SEL_W-1:0]  wdsel,
  output logic [TNEW_W-1:0] tnew,
  output logic [PC_W-1:0]   pc4,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [TNEW_W-1:0] rs_tuse,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [TNEW_W-1:0] rt_tuse,
  output logic              rs_fwd,
  output logic              rs_stall,
  output logic              rt_fwd,
  output logic              rt_stall
);

  localparam logic DEC_EN   = (DEC_ON_CAPTURE != 0);
  localparam logic ZERO_HAZ = (ZERO_REG_HAZ != 0);

  logic [TNEW_W-1:0] tnew_cap;
  logic              rs_match;
  logic              rt_match;

  // Tnew as it enters this stage: one cycle has elapsed, saturating at 0
  always_comb begin
    tnew_cap = in_tnew;
    if (DEC_EN && (in_tnew != '0)) begin
      tnew_cap = in_tnew - TNEW_W'(1);
    end
  end

  // Stage register: reset > flush > en > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      regwr <= 1'b0;
      waddr <= '0;
      wdsel <= '0;
      tnew  <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      regwr <= 1'b0;
      waddr <= '0;
      wdsel <= '0;
      tnew  <= '0;
      pc4   <= '0;
    end else if (en) begin
      valid <= in_valid;
      regwr <= in_regwr & in_valid;
      waddr <= in_waddr;
      wdsel <= in_wdsel;
      tnew  <= tnew_cap;
      pc4   <= in_pc4;
    end
  end

  // Hazard results use only registered state plus the consumer operands
  always_comb begin
    rs_match = valid & regwr & (waddr == rs_addr) & ((rs_addr != '0) | ZERO_HAZ);
    rt_match = valid & regwr & (waddr == rt_addr) & ((rt_addr != '0) | ZERO_HAZ);
    rs_fwd   = rs_match & (tnew == '0);
    rs_stall = rs_match & (tnew > rs_tuse);
    rt_fwd   = rt_match & (tnew == '0);
    rt_stall = rt_match & (tnew > rt_tuse);
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed plus short random checks of pipe_stage_ctrl.
// Two instances share all inputs: dut (address 0 never matches) and dut_z
// (address 0 takes part in hazard matching). Expected bundles are queued
// when stimulus is driven and popped after the capturing edge.
module tb_pipe_stage_ctrl;

  typedef struct packed {
    logic       valid;
    logic       regwr;
    logic [4:0] waddr;
    logic [1:0] wdsel;
    logic [1:0] tnew;
    logic [31:0] pc4;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  // clock/reset and DUT signals
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, flush, in_valid, in_regwr;
  logic [4:0]  in_waddr, rs_addr, rt_addr;
  logic [1:0]  in_wdsel, in_tnew, rs_tuse, rt_tuse;
  logic [31:0] in_pc4;
  logic        valid, regwr;
  logic [4:0]  waddr;
  logic [1:0]  wdsel, tnew;
  logic [31:0] pc4;
  logic        rs_fwd, rs_stall, rt_fwd, rt_stall;
  logic        z_valid, z_regwr;
  logic [4:0]  z_waddr;
  logic [1:0]  z_wdsel, z_tnew;
  logic [31:0] z_pc4;
  logic        z_rs_fwd, z_rs_stall, z_rt_fwd, z_rt_stall;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.DEC_ON_CAPTURE(1), .ZERO_REG_HAZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_regwr(in_regwr), .in_waddr(in_waddr),
    .in_wdsel(in_wdsel), .in_tnew(in_tnew), .in_pc4(in_pc4),
    .valid(valid), .regwr(regwr), .waddr(waddr), .wdsel(wdsel),
    .tnew(tnew), .pc4(pc4),
    .rs_addr(rs_addr), .rs_tuse(rs_tuse), .rt_addr(rt_addr), .rt_tuse(rt_tuse),
    .rs_fwd(rs_fwd), .rs_stall(rs_stall), .rt_fwd(rt_fwd), .rt_stall(rt_stall)
  );

  pipe_stage_ctrl #(.DEC_ON_CAPTURE(1), .ZERO_REG_HAZ(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_regwr(in_regwr), .in_waddr(in_waddr),
    .in_wdsel(in_wdsel), .in_tnew(in_tnew), .in_pc4(in_pc4),
    .valid(z_valid), .regwr(z_regwr), .waddr(z_waddr), .wdsel(z_wdsel),
    .tnew(z_tnew), .pc4(z_pc4),
    .rs_addr(rs_addr), .rs_tuse(rs_tuse), .rt_addr(rt_addr), .rt_tuse(rt_tuse),
    .rs_fwd(z_rs_fwd), .rs_stall(z_rs_stall), .rt_fwd(z_rt_fwd), .rt_stall(z_rt_stall)
  );

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  bundle_t       cur;
  int            pass_cnt  = 0;
  int            fail_cnt  = 0;
  int            total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected {fwd, stall} for one consumer operand
  function automatic logic [1:0] haz_exp(input bundle_t b, input logic [4:0] a,
                                         input logic [1:0] tu, input bit zrh);
    logic m;
    m = b.valid && b.regwr && (b.waddr == a) && ((a != 5'd0) || zrh);
    return {m && (b.tnew == 2'd0), m && (b.tnew > tu)};
  endfunction

  // driver: present inputs and queue the bundle the next edge must produce
  task automatic drive(input logic e, input logic f, input logic v, input logic rw,
                       input logic [4:0] wa, input logic [1:0] ws,
                       input logic [1:0] tn, input logic [31:0] pc);
    bundle_t nxt;
    en = e; flush = f; in_valid = v; in_regwr = rw;
    in_waddr = wa; in_wdsel = ws; in_tnew = tn; in_pc4 = pc;
    if (f) nxt = '0;
    else if (e) begin
      nxt.valid = v;
      nxt.regwr = rw & v;
      nxt.waddr = wa;
      nxt.wdsel = ws;
      nxt.tnew  = (tn == 2'd0) ? 2'd0 : tn - 2'd1;
      nxt.pc4   = pc;
    end else nxt = cur;
    exp_q.push_back(BW'(nxt));
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".valid"}, valid, cur.valid);
    check({tag, ".regwr"}, regwr, cur.regwr);
    check({tag, ".waddr"}, waddr, cur.waddr);
    check({tag, ".wdsel"}, wdsel, cur.wdsel);
    check({tag, ".tnew"},  tnew,  cur.tnew);
    check({tag, ".pc4"},   pc4,   cur.pc4);
  endtask

  // advance one edge, pop the expected bundle and compare
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".q_nonempty"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      cur = bundle_t'(exp_q.pop_front());
      check_fields(tag);
    end
  endtask

  task automatic check_haz(input string tag, input logic [4:0] rsa, input logic [1:0] rsu,
                           input logic [4:0] rta, input logic [1:0] rtu);
    logic [1:0] e_rs, e_rt, ez_rs;
    rs_addr = rsa; rs_tuse = rsu; rt_addr = rta; rt_tuse = rtu;
    #1;
    e_rs  = haz_exp(cur, rsa, rsu, 1'b0);
    e_rt  = haz_exp(cur, rta, rtu, 1'b0);
    ez_rs = haz_exp(cur, rsa, rsu, 1'b1);
    check({tag, ".rs_fwd"},     rs_fwd,     e_rs[1]);
    check({tag, ".rs_stall"},   rs_stall,   e_rs[0]);
    check({tag, ".rt_fwd"},     rt_fwd,     e_rt[1]);
    check({tag, ".rt_stall"},   rt_stall,   e_rt[0]);
    check({tag, ".z_rs_fwd"},   z_rs_fwd,   ez_rs[1]);
    check({tag, ".z_rs_stall"}, z_rs_stall, ez_rs[0]);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    en = 0; flush = 0; in_valid = 0; in_regwr = 0;
    in_waddr = 0; in_wdsel = 0; in_tnew = 0; in_pc4 = 0;
    rs_addr = 0; rs_tuse = 0; rt_addr = 0; rt_tuse = 0;
    cur = '0;
    #12;
    check_fields("reset");
    rst_n = 1'b1;

    // capture with decrement: tnew 2 -> 1
    drive(1, 0, 1, 1, 5'd5, 2'b01, 2'd2, 32'h3004);
    tick("cap_dec");
    check("cap_dec.tnew_lit", tnew, 2'd1);
    check("cap_dec.pc4_lit", pc4, 32'h3004);

    // hazard against tnew=1, waddr=5
    check_haz("haz_tuse0", 5'd5, 2'd0, 5'd6, 2'd0);
    check("haz_tuse0.stall_lit", rs_stall, 1'b1);
    check_haz("haz_tuse1", 5'd5, 2'd1, 5'd6, 2'd0);
    check("haz_tuse1.stall_lit", rs_stall, 1'b0);
    check_haz("haz_same", 5'd5, 2'd0, 5'd5, 2'd0);
    check("haz_same.rt_eq_rs", rt_stall, rs_stall);

    // stall three cycles, tnew must not count down
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 5'd17, 2'b10, 2'd3, 32'hdead_beef);
      tick("hold");
    end
    check("hold.tnew_lit", tnew, 2'd1);

    // flush wins over en
    drive(1, 1, 1, 1, 5'd12, 2'b10, 2'd3, 32'h4000);
    tick("flush");

    // recapture with tnew 0: no underflow; now forwards
    drive(1, 0, 1, 1, 5'd5, 2'b00, 2'd0, 32'h3008);
    tick("cap_zero");
    check("cap_zero.tnew_lit", tnew, 2'd0);
    check_haz("haz_fwd", 5'd5, 2'd0, 5'd6, 2'd0);
    check("haz_fwd.fwd_lit", rs_fwd, 1'b1);

    // zero register
    drive(1, 0, 1, 1, 5'd0, 2'b00, 2'd0, 32'h300c);
    tick("zero_reg");
    check_haz("haz_zero", 5'd0, 2'd0, 5'd0, 2'd0);
    check("haz_zero.fwd_lit", rs_fwd, 1'b0);
    check("haz_zero.z_fwd_lit", z_rs_fwd, 1'b1);

    // invalid bubble kills regwr
    drive(1, 0, 0, 1, 5'd9, 2'b01, 2'd1, 32'h3010);
    tick("inv_bubble");
    check("inv_bubble.regwr_lit", regwr, 1'b0);
    check_haz("haz_inv", 5'd9, 2'd0, 5'd9, 2'd0);

    // reserved wdsel passes through, tnew 3 -> 2
    drive(1, 0, 1, 1, 5'd31, 2'b11, 2'd3, 32'hffff_fffc);
    tick("wdsel_rsv");
    check_haz("haz_rsv", 5'd31, 2'd1, 5'd31, 2'd2);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom);
      tick("rand");
      check_haz("rand_haz", 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // reset mid-operation: waddr=8, tnew=2 loaded then reset between edges
    drive(1, 0, 1, 1, 5'd8, 2'b01, 2'd3, 32'h5000);
    tick("pre_rst");
    check("pre_rst.tnew_lit", tnew, 2'd2);
    en = 1'b1;
    rst_n = 1'b0;
    #1;
    cur = '0;
    exp_q.delete();
    check_fields("rst_async");
    check_haz("rst_haz", 5'd8, 2'd0, 5'd8, 2'd0);
    rst_n = 1'b1;
    #1;
    check_fields("rst_released");
    drive(0, 0, 1, 1, 5'd8, 2'b01, 2'd3, 32'h5000);
    tick("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
